encrypt_out_packer: RTL

- Sits directly downstream of the encryption pipeline and consumes its byte stream (encrypted valid strobe plus 8-bit encrypted data).
- Packs bytes little-endian into 32-bit words with byte enables and buffers them in a small FIFO.
- Presents the words on a valid/ready master interface.
- The encryption pipeline has no backpressure, so the block provides an almost-full hint (to drop upstream en) and a sticky overflow flag.

---
 rtl/encrypt_pkg.sv | 20 ++
 rtl/encrypt_out_fifo.sv | 59 +++++
 rtl/encrypt_out_packer.sv | 89 ++++++++
 3 files changed

// File: rtl/encrypt_pkg.sv
// Shared types for the encrypted-byte output path: packed word, byte enables
// and the FIFO entry that carries them together.
package encrypt_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  be_t;

   typedef struct packed {
      be_t   be;
      word_t data;
   } out_entry_t;

   // Contiguous low-order enables for n valid bytes (n = 0..4).
   function automatic be_t be_from_count(input logic [2:0] n);
      return be_t'((5'd1 << n) - 5'd1);
   endfunction

endpackage

// File: rtl/encrypt_out_fifo.sv
// Synchronous word FIFO with wrap-bit pointers; a push while full succeeds only
// when a pop frees the slot in the same cycle, otherwise the word is dropped.
module encrypt_out_fifo
   import encrypt_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int AFULL_LVL = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic [$bits(out_entry_t)-1:0]   wr_entry,
   input  logic                            pop,
   output logic [$bits(out_entry_t)-1:0]   head,
   output logic                            full,
   output logic                            empty,
   output logic                            almost_full,
   output logic                            drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

   out_entry_t  mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [AW:0] occ;
   logic [AW:0] occ_next;
   logic        pop_ok;
   logic        push_ok;

   assign occ      = wptr - rptr;
   assign full     = (occ == DEPTH_CNT);
   assign empty    = (wptr == rptr);
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign drop     = push & ~push_ok;
   assign occ_next = occ + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   assign head     = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr        <= '0;
         rptr        <= '0;
         almost_full <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wptr[AW-1:0]] <= wr_entry;
            wptr              <= wptr + 1'b1;
         end
         if (pop_ok) rptr <= rptr + 1'b1;
         // Registered from next-state occupancy so it lines up with the pointers.
         almost_full <= (occ_next >= AFULL_CNT);
      end
   end

endmodule

// File: rtl/encrypt_out_packer.sv
// Packs the encryption pipeline's byte stream little-endian into 32-bit words
// with byte enables, buffers them and presents them on a valid/ready master.
module encrypt_out_packer
   import encrypt_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int AFULL_LVL = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        v,
   input  logic [7:0]  din,
   input  logic        flush,
   input  logic        m_ready,
   output logic        m_valid,
   output logic [31:0] m_data,
   output logic [3:0]  m_be,
   output logic        almost_full,
   output logic        overflow,
   input  logic        clr_ovf
);

   logic [1:0]  cnt;
   logic [23:0] hold;
   logic [2:0]  nbytes;
   word_t       cur_word;
   logic        push;
   out_entry_t  wr_entry;
   out_entry_t  head_entry;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_drop;

   assign nbytes = {1'b0, cnt} + {2'b00, v};
   assign push   = (nbytes == 3'(BYTES_PER_WORD)) | (flush & (nbytes != 3'd0));

   // Unused upper lanes stay zero because hold is cleared on every push.
   always_comb begin
      cur_word = {8'h00, hold};
      if (v) begin
         for (int i = 0; i < BYTES_PER_WORD; i++)
            if (cnt == 2'(i)) cur_word[i*8 +: 8] = din;
      end
   end

   assign wr_entry.data = cur_word;
   assign wr_entry.be   = be_from_count(nbytes);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         hold     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            cnt  <= '0;
            hold <= '0;
         end else if (v) begin
            for (int i = 0; i < BYTES_PER_WORD - 1; i++)
               if (cnt == 2'(i)) hold[i*8 +: 8] <= din;
            cnt <= cnt + 2'd1;
         end
         // A drop in the same cycle wins over the clear.
         if (fifo_drop)    overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   encrypt_out_fifo #(
      .DEPTH     (DEPTH),
      .AFULL_LVL (AFULL_LVL)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .wr_entry    (wr_entry),
      .pop         (m_ready),
      .head        (head_entry),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .almost_full (almost_full),
      .drop        (fifo_drop)
   );

   assign m_valid = ~fifo_empty;
   assign m_data  = head_entry.data;
   assign m_be    = head_entry.be;

endmodule
